pattern_hit_monitor: RTL and testbench

//  Downstream consumer of the 1-0-1 pattern detector's single-bit hit output.

---
 rtl/pattern_hit_monitor.sv | 111 +++++++++++
 tb/tb_pattern_hit_monitor.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_hit_monitor.sv
// Counts detector hits over fixed WIN_LEN-cycle windows. A window reaching THRESH hits
// produces one report record over a valid/ready handshake and sets a sticky alarm.
module pattern_hit_monitor #(
    parameter int WIN_LEN = 16,
    parameter int THRESH  = 3,
    parameter int CNT_W   = 8,
    parameter int IDX_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             hit_in,
    input  logic             clr_alarm,
    input  logic             rpt_ready,
    output logic             rpt_valid,
    output logic [CNT_W-1:0] rpt_count,
    output logic [IDX_W-1:0] rpt_win_idx,
    output logic             alarm,
    output logic             busy
);
    localparam int WC_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] REPORT = 2'd2;

    localparam logic [WC_W-1:0]  WIN_LAST = WC_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W:0]   THR      = (CNT_W + 1)'(THRESH);

    logic [1:0]       state;
    logic [WC_W-1:0]  win_cnt;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] final_cnt;
    logic [IDX_W-1:0] win_idx;
    logic             win_end;
    logic             report_set;

    // Running count including this cycle's hit; saturates instead of wrapping.
    always_comb begin
        final_cnt = hit_cnt;
        if (hit_in && (hit_cnt != CNT_MAX))
            final_cnt = hit_cnt + 1'b1;
    end

    assign win_end    = (state == RUN) && enable && (win_cnt == WIN_LAST);
    assign report_set = win_end && ({1'b0, final_cnt} >= THR);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            win_cnt     <= '0;
            hit_cnt     <= '0;
            win_idx     <= '0;
            rpt_valid   <= 1'b0;
            rpt_count   <= '0;
            rpt_win_idx <= '0;
            alarm       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state   <= RUN;
                        win_cnt <= '0;
                        hit_cnt <= '0;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        // Abort: the partial window is discarded, win_idx is kept.
                        state   <= IDLE;
                        win_cnt <= '0;
                        hit_cnt <= '0;
                    end else if (win_end) begin
                        win_cnt <= '0;
                        hit_cnt <= '0;
                        win_idx <= win_idx + 1'b1;
                        if (report_set) begin
                            state       <= REPORT;
                            rpt_valid   <= 1'b1;
                            rpt_count   <= final_cnt;
                            rpt_win_idx <= win_idx;
                        end
                    end else begin
                        win_cnt <= win_cnt + 1'b1;
                        hit_cnt <= final_cnt;
                    end
                end
                REPORT: begin
                    // enable is only looked at once the record has been taken.
                    if (rpt_ready) begin
                        rpt_valid <= 1'b0;
                        state     <= enable ? RUN : IDLE;
                        win_cnt   <= '0;
                        hit_cnt   <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rpt_valid <= 1'b0;
                end
            endcase

            if (report_set)
                alarm <= 1'b1;
            else if (clr_alarm)
                alarm <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pattern_hit_monitor.sv
// Bench for pattern_hit_monitor: directed table, hand-written corner sequences and a
// random run against a window/report model kept as plain integers.
module tb_pattern_hit_monitor;
    localparam int WIN  = 16;
    localparam int TH   = 3;
    localparam int CMAX = 255;
    localparam int IMOD = 256;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0, hit_in = 1'b0, clr_alarm = 1'b0, rpt_ready = 1'b0;
    logic       rpt_valid, alarm, busy;
    logic [7:0] rpt_count, rpt_win_idx;

    logic       s_en = 1'b0, s_hit = 1'b0, s_clr = 1'b0, s_rdy = 1'b0;
    logic       s_valid, s_alarm, s_busy;
    logic [1:0] s_count;
    logic [7:0] s_idx;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    pattern_hit_monitor u_dut (
        .clk(clk), .rst(rst), .enable(enable), .hit_in(hit_in), .clr_alarm(clr_alarm),
        .rpt_ready(rpt_ready), .rpt_valid(rpt_valid), .rpt_count(rpt_count),
        .rpt_win_idx(rpt_win_idx), .alarm(alarm), .busy(busy)
    );

    pattern_hit_monitor #(.WIN_LEN(16), .THRESH(3), .CNT_W(2), .IDX_W(8)) u_sat (
        .clk(clk), .rst(rst), .enable(s_en), .hit_in(s_hit), .clr_alarm(s_clr),
        .rpt_ready(s_rdy), .rpt_valid(s_valid), .rpt_count(s_count),
        .rpt_win_idx(s_idx), .alarm(s_alarm), .busy(s_busy)
    );

    // Reference model: a window is "open" with a position and a plain hit tally;
    // a report is "pending" with its record. No state encoding is reproduced.
    bit m_open, m_pend, m_alarm;
    int m_pos, m_hits, m_idx, m_rcnt, m_ridx;

    task automatic model_reset();
        m_open = 0; m_pend = 0; m_alarm = 0;
        m_pos = 0; m_hits = 0; m_idx = 0; m_rcnt = 0; m_ridx = 0;
    endtask

    task automatic model_step(input bit en, input bit hit, input bit clr, input bit rdy);
        bit fired = 0;
        if (m_pend) begin
            if (rdy) begin
                m_pend = 0; m_open = en; m_pos = 0; m_hits = 0;
            end
        end else if (m_open) begin
            if (!en) begin
                m_open = 0; m_pos = 0; m_hits = 0;
            end else begin
                m_hits += int'(hit);
                if (m_pos == WIN - 1) begin
                    int fin = (m_hits > CMAX) ? CMAX : m_hits;
                    if (fin >= TH) begin
                        m_pend = 1; m_open = 0; m_rcnt = fin; m_ridx = m_idx; fired = 1;
                    end
                    m_idx = (m_idx + 1) % IMOD;
                    m_pos = 0; m_hits = 0;
                end else begin
                    m_pos++;
                end
            end
        end else if (en) begin
            m_open = 1; m_pos = 0; m_hits = 0;
        end
        if (fired) m_alarm = 1;
        else if (clr) m_alarm = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("valid", 32'(rpt_valid), 32'(m_pend));
        check("busy", 32'(busy), 32'(m_open | m_pend));
        check("alarm", 32'(alarm), 32'(m_alarm));
        check("count", 32'(rpt_count), 32'(m_rcnt));
        check("win_idx", 32'(rpt_win_idx), 32'(m_ridx));
    endtask

    // Called just after a falling edge: drive, clock, update model, land on next falling edge.
    task automatic step(input bit en, input bit hit, input bit clr, input bit rdy);
        enable = en; hit_in = hit; clr_alarm = clr; rpt_ready = rdy;
        @(posedge clk);
        model_step(en, hit, clr, rdy);
        @(negedge clk);
    endtask

    task automatic step_chk(input bit en, input bit hit, input bit clr, input bit rdy);
        step(en, hit, clr, rdy);
        check_model();
    endtask

    task automatic do_reset();
        enable = 0; hit_in = 0; clr_alarm = 0; rpt_ready = 0;
        s_en = 0; s_hit = 0; s_clr = 0; s_rdy = 0;
        @(negedge clk);
        rst = 1;
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    typedef struct {
        bit en, hit, clr, rdy;
        int n;
        bit e_valid, e_busy, e_alarm;
        int e_count, e_idx;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Hits on window cycles 2, 5 and 9; report one cycle after cycle 15.
        tbl.push_back('{1,0,0,1,1, 0,1,0,0,0});  // enter window
        tbl.push_back('{1,0,0,1,2, 0,1,0,0,0});  // cycles 0-1
        tbl.push_back('{1,1,0,1,1, 0,1,0,0,0});  // cycle 2
        tbl.push_back('{1,0,0,1,2, 0,1,0,0,0});  // cycles 3-4
        tbl.push_back('{1,1,0,1,1, 0,1,0,0,0});  // cycle 5
        tbl.push_back('{1,0,0,1,3, 0,1,0,0,0});  // cycles 6-8
        tbl.push_back('{1,1,0,1,1, 0,1,0,0,0});  // cycle 9
        tbl.push_back('{1,0,0,1,5, 0,1,0,0,0});  // cycles 10-14
        tbl.push_back('{1,0,0,1,1, 1,1,1,3,0});  // cycle 15 -> report visible
        tbl.push_back('{1,0,0,1,1, 0,1,1,3,0});  // handshake, valid drops
        tbl.push_back('{1,1,0,1,1, 0,1,1,3,0});  // next window running

        do_reset();
        check_model();
        check("reset_busy", 32'(busy), 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            for (int k = 0; k < tbl[i].n; k++)
                step(tbl[i].en, tbl[i].hit, tbl[i].clr, tbl[i].rdy);
            check($sformatf("tbl%0d_valid", i), 32'(rpt_valid), 32'(tbl[i].e_valid));
            check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            check($sformatf("tbl%0d_alarm", i), 32'(alarm), 32'(tbl[i].e_alarm));
            check($sformatf("tbl%0d_count", i), 32'(rpt_count), 32'(tbl[i].e_count));
            check($sformatf("tbl%0d_idx", i), 32'(rpt_win_idx), 32'(tbl[i].e_idx));
        end

        // Reset mid-window with hits pending: outputs clear without a clock edge.
        step_chk(1, 1, 0, 1);
        step_chk(1, 1, 0, 1);
        rst = 1;
        #1;
        model_reset();
        check("rst_valid", 32'(rpt_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_alarm", 32'(alarm), 32'd0);
        check("rst_count", 32'(rpt_count), 32'd0);
        check("rst_idx", 32'(rpt_win_idx), 32'd0);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 20; i++) step_chk(0, 1, 0, 1);
        check("post_rst_valid", 32'(rpt_valid), 32'd0);

        // Two hits in window 0, three in window 1.
        do_reset();
        step_chk(1, 0, 0, 0);
        for (int c = 0; c < WIN; c++) step_chk(1, (c < 2), 0, 0);
        check("w0_no_report", 32'(rpt_valid), 32'd0);
        for (int c = 0; c < WIN; c++) step_chk(1, (c == 4 || c == 8 || c == 15), 0, 0);
        check("w1_valid", 32'(rpt_valid), 32'd1);
        check("w1_count", 32'(rpt_count), 32'd3);
        check("w1_idx", 32'(rpt_win_idx), 32'd1);

        // Consumer stalls 5 cycles with hit_in high; record holds, hits ignored.
        for (int c = 0; c < 5; c++) step_chk(1, 1, 0, 0);
        check("stall_valid", 32'(rpt_valid), 32'd1);
        check("stall_count", 32'(rpt_count), 32'd3);
        check("stall_idx", 32'(rpt_win_idx), 32'd1);
        step_chk(1, 1, 0, 1);
        for (int c = 0; c < WIN; c++) step_chk(1, (c == 0 || c == 1 || c == 2), 0, 0);
        check("after_stall_count", 32'(rpt_count), 32'd3);
        check("after_stall_idx", 32'(rpt_win_idx), 32'd2);
        step_chk(1, 0, 0, 1);

        // Four hits, then abort at window cycle 7; win_idx must not advance.
        do_reset();
        step_chk(1, 0, 0, 1);
        for (int c = 0; c < 7; c++) step_chk(1, (c < 4), 0, 1);
        step_chk(0, 1, 0, 1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(rpt_valid), 32'd0);
        step_chk(0, 0, 0, 1);
        step_chk(1, 0, 0, 1);
        for (int c = 0; c < WIN; c++) step_chk(1, (c >= 13), 0, 1);
        check("reenable_valid", 32'(rpt_valid), 32'd1);
        check("reenable_idx", 32'(rpt_win_idx), 32'd0);

        // Randomized run against the model.
        do_reset();
        for (int i = 0; i < 3000; i++)
            step_chk(($urandom_range(0, 19) != 0), ($urandom_range(0, 9) < 3),
                     ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6));

        // 2-bit counter saturates; clear on the report-set cycle loses to the set.
        do_reset();
        s_en = 1; s_rdy = 1;
        @(negedge clk);
        for (int c = 0; c < WIN; c++) begin
            s_hit = 1;
            s_clr = (c == WIN - 1);
            @(negedge clk);
            if (c == WIN - 2) check("sat_busy", 32'(s_busy), 32'd1);
        end
        s_clr = 0; s_hit = 0;
        check("sat_valid", 32'(s_valid), 32'd1);
        check("sat_count", 32'(s_count), 32'd3);
        check("sat_alarm", 32'(s_alarm), 32'd1);
        check("sat_idx", 32'(s_idx), 32'd0);
        @(negedge clk);
        check("sat_valid_drop", 32'(s_valid), 32'd0);
        s_clr = 1;
        @(negedge clk);
        check("sat_alarm_clr", 32'(s_alarm), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
